param_data_memory: RTL and testbench
====================================

Name: param_data_memory

Overview:
Parametrised single-port data memory, the next generation of the 8x32 datapath RAM. It adds a valid/ready request port, a registered read response with 1-cycle latency, and a post-reset clear sequencer that writes CLEAR_VAL to every word. It sits between the multicycle controller/datapath and storage, replacing the combinational-read RAM.

Parameters:
DATA_W, 8, word width in bits
DEPTH, 32, number of words (need not be a power of two, >=2)
ADDR_W, $clog2(DEPTH), address width
CLEAR_VAL, '0, value written to every word by the clear sequencer

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  memory can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read data valid (one-cycle pulse per accepted read)
rsp_rdata  out  DATA_W  read data
busy  out  1  clear sequence in progress

Behaviour:
- FSM states: CLEAR, READY. rst=1 at an edge -> state=CLEAR, clr_addr=0, rsp_valid=0, rsp_rdata=0. Reset applies regardless of state, including mid-clear (clear restarts at 0).
- Outputs: busy = (state==CLEAR); req_ready = (state==READY) and rst==0. Both are combinational from state.
- CLEAR: each cycle, mem[clr_addr] <= CLEAR_VAL and clr_addr++. On the cycle clr_addr==DEPTH-1 the last word is written and next state=READY. Clear takes exactly DEPTH cycles after rst deasserts. Requests are not accepted and req_valid is ignored.
- READY: a request is accepted when req_valid && req_ready.
- Accepted write: mem[req_addr] <= req_wdata at that edge. rsp_valid=0 next cycle.
- Accepted read: rsp_rdata <= mem[req_addr] and rsp_valid <= 1 at that edge, so data is visible 1 cycle after acceptance.
- Back-to-back traffic: one request per cycle at full throughput. A read in the cycle after a write to the same address returns the new data.
- No accepted read in a cycle -> rsp_valid <= 0 and rsp_rdata holds its previous value.
- Out-of-range address (req_addr >= DEPTH, possible when DEPTH is not a power of two): a write is dropped. A read returns rsp_rdata=0 with rsp_valid=1.
- No file preload. Contents are undefined until the first clear completes.

Optional Feature:
- Macro: PARAM_DATA_MEMORY_PARITY_EN.
- Defined:
  - Each word gains a stored even-parity bit, computed on every write and on clear.
  - Added input inj_parity_flip (1 bit): when high on an accepted write, the stored parity bit is inverted (for error injection).
  - Added output rsp_parity_err (1 bit), registered alongside rsp_valid. It is 1 when an accepted in-range read finds stored parity != ^data. Reset value 0. It is 0 whenever rsp_valid=0.
- Undefined: no parity storage, neither port exists, and behaviour is otherwise identical.

Decomposition:
- Package mem_pkg: typedef enum logic {CLEAR, READY} mem_state_t; localparams for default DATA_W/DEPTH; function even_parity.
- One sub-module, mem_clear_seq: owns state and clr_addr, and produces busy, clear write-enable and clear address. The top muxes clear vs request writes.

Test Plan:
1. Default params, rst high 2 cycles then low -> busy=1 and req_ready=0 for exactly 32 cycles, then busy=0 and req_ready=1; reads of addr 0..31 return 0x00.
2. Write 0xA5 to addr 7, read addr 7 next cycle -> rsp_valid=1 with rsp_rdata=0xA5 one cycle after the read handshake; no rsp_valid after the write.
3. Interleave 16 writes and 16 reads back-to-back with req_valid held high -> one acceptance per cycle, correct data each read, rsp_rdata holds during idle cycles.
4. Assert rst at clear cycle 10 -> busy stays 1, clear restarts and completes 32 cycles after rst deasserts; req_valid during clear is never accepted.
5. DEPTH=20, ADDR_W=5: write 0x3C to addr 25, then read addr 25 -> rsp_rdata=0x00 with rsp_valid=1; addr 0..19 unchanged.
6. With PARITY_EN: write 0x01 with inj_parity_flip=1 to addr 3, read -> rsp_parity_err=1; write 0x01 normally to addr 4, read -> rsp_parity_err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types, default sizes and parity helper for param_data_memory.
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_t;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_ADDR_W = $clog2(DEF_DEPTH);
  localparam int unsigned PAR_MAX_W  = 64;

  // Even-parity bit: makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/param_data_memory_if.sv
// Request/response bus for param_data_memory.
// Optional parity ports exist only when PARAM_DATA_MEMORY_PARITY_EN is defined.
interface param_data_memory_if
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
  logic              inj_parity_flip;
  logic              rsp_parity_err;
`endif

`ifdef PARAM_DATA_MEMORY_PARITY_EN
  modport master (
    output req_valid, req_we, req_addr, req_wdata, inj_parity_flip,
    input  req_ready, rsp_valid, rsp_rdata, busy, rsp_parity_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, inj_parity_flip,
    output req_ready, rsp_valid, rsp_rdata, busy, rsp_parity_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
`endif

endinterface

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: walks every word once, then hands the array to requests.
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  mem_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= READY;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        READY: state <= READY;
      endcase
    end
  end

  // Clear writes are suppressed while reset is held so the walk always restarts at word 0.
  assign busy   = (state == CLEAR);
  assign clr_we = busy & ~rst;

endmodule

// File: rtl/param_data_memory.sv
// Single-port data memory with valid/ready requests, 1-cycle registered reads and post-reset clear.
// Define PARAM_DATA_MEMORY_PARITY_EN to add per-word even parity with error injection/reporting.
module param_data_memory
  import mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter int unsigned       DEPTH     = DEF_DEPTH,
  parameter int unsigned       ADDR_W    = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic                clk,
  input logic                rst,
  param_data_memory_if.slave bus
);

  localparam int unsigned CMP_W = ADDR_W + 1;

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  mem_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic req_ready;
  logic accept;
  logic in_range;

  assign req_ready = ~busy & ~rst;
  assign accept    = bus.req_valid & req_ready;
  // Widened compare so DEPTH == 2**ADDR_W does not wrap to zero.
  assign in_range  = {1'b0, bus.req_addr} < CMP_W'(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
  logic              wr_par;
`endif

  // Clear sequencer owns the write port while busy; otherwise accepted in-range writes.
  always_comb begin
    wr_en   = accept & bus.req_we & in_range;
    wr_addr = bus.req_addr;
    wr_data = bus.req_wdata;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
    wr_par  = even_parity(PAR_MAX_W'(bus.req_wdata)) ^ bus.inj_parity_flip;
`endif
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = CLEAR_VAL;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
      wr_par  = even_parity(PAR_MAX_W'(CLEAR_VAL));
`endif
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef PARAM_DATA_MEMORY_PARITY_EN
  logic              par_mem [DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr]     <= wr_data;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
      par_mem[wr_addr] <= wr_par;
`endif
    end
  end

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
  logic              rsp_parity_err;
`endif

  // Read response register; rdata holds between reads, out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
      rsp_parity_err <= 1'b0;
`endif
    end else if (accept && !bus.req_we) begin
      rsp_valid      <= 1'b1;
      rsp_rdata      <= in_range ? mem[bus.req_addr] : '0;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
      rsp_parity_err <= in_range &&
                        (par_mem[bus.req_addr] != even_parity(PAR_MAX_W'(mem[bus.req_addr])));
`endif
    end else begin
      rsp_valid      <= 1'b0;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
      rsp_parity_err <= 1'b0;
`endif
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.busy           = busy;
  assign bus.rsp_valid      = rsp_valid;
  assign bus.rsp_rdata      = rsp_rdata;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
  assign bus.rsp_parity_err = rsp_parity_err;
`endif

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory: default 32-word instance plus a 20-word instance.
module tb_param_data_memory;

  localparam int unsigned DW  = 8;
  localparam int unsigned DA  = 32;
  localparam int unsigned AWA = 5;
  localparam int unsigned DB  = 20;
  localparam int unsigned AWB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  param_data_memory_if #(.DATA_W(DW), .ADDR_W(AWA)) a ();
  param_data_memory_if #(.DATA_W(DW), .ADDR_W(AWB)) b ();

  param_data_memory #(.DATA_W(DW), .DEPTH(DA), .ADDR_W(AWA), .CLEAR_VAL(8'h00)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a)
  );

  param_data_memory #(.DATA_W(DW), .DEPTH(DB), .ADDR_W(AWB), .CLEAR_VAL(8'h00)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] ma[DA];
  logic          ea[DA];
  logic [DW-1:0] mb[DB];
  logic [DW-1:0] last_a;
  logic [DW-1:0] last_b;
  int            passed;
  int            total;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a.req_valid = 1'b0; a.req_we = 1'b0; a.req_addr = '0; a.req_wdata = '0;
    b.req_valid = 1'b0; b.req_we = 1'b0; b.req_addr = '0; b.req_wdata = '0;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
    a.inj_parity_flip = 1'b0;
    b.inj_parity_flip = 1'b0;
`endif
  endtask

  // Drive one cycle on instance a and push the expected response from the bench model.
  task automatic drive_a(input logic v, input logic we, input logic [AWA-1:0] addr,
                         input logic [DW-1:0] d, input logic flip);
    exp_t x;
    a.req_valid = v; a.req_we = we; a.req_addr = addr; a.req_wdata = d;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
    a.inj_parity_flip = flip;
`endif
    x.v = v & ~we;
    x.d = x.v ? ma[addr] : 8'h00;
    x.e = x.v ? ea[addr] : 1'b0;
    if (v && we) begin
      ma[addr] = d;
      ea[addr] = flip;
    end
    qa.push_back(x);
  endtask

  task automatic drive_b(input logic v, input logic we, input logic [AWB-1:0] addr,
                         input logic [DW-1:0] d);
    exp_t x;
    logic inr;
    b.req_valid = v; b.req_we = we; b.req_addr = addr; b.req_wdata = d;
    inr = (int'(addr) < int'(DB));
    x.v = v & ~we;
    x.d = (x.v && inr) ? mb[addr] : 8'h00;
    x.e = 1'b0;
    if (v && we && inr) mb[addr] = d;
    qb.push_back(x);
  endtask

  task automatic reset_models();
    for (int i = 0; i < int'(DA); i++) begin ma[i] = 8'h00; ea[i] = 1'b0; end
    for (int i = 0; i < int'(DB); i++) mb[i] = 8'h00;
    last_a = 8'h00;
    last_b = 8'h00;
    qa.delete();
    qb.delete();
  endtask

  task automatic test_reset();
    int na, nb, bad;
    idle_all();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) tick();
    reset_models();
    total++;
    if (a.rsp_valid !== 1'b0 || a.rsp_rdata !== 8'h00 || a.busy !== 1'b1 || a.req_ready !== 1'b0 ||
        b.busy !== 1'b1 || b.req_ready !== 1'b0)
      $display("FAIL reset_state: a v=%b d=%h busy=%b rdy=%b b busy=%b rdy=%b, required 0 00 1 0 / 1 0",
               a.rsp_valid, a.rsp_rdata, a.busy, a.req_ready, b.busy, b.req_ready);
    else passed++;
`ifdef PARAM_DATA_MEMORY_PARITY_EN
    total++;
    if (a.rsp_parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b, required 0", a.rsp_parity_err);
    else passed++;
`endif
    rst_a = 1'b0; rst_b = 1'b0;
    a.req_valid = 1'b1; a.req_we = 1'b0;
    b.req_valid = 1'b1; b.req_we = 1'b0;
    na = 0; nb = 0; bad = 0;
    for (int c = 0; c < 100 && (a.busy === 1'b1 || b.busy === 1'b1); c++) begin
      if (a.busy === 1'b1) begin na++; if (a.req_ready !== 1'b0 || a.rsp_valid !== 1'b0) bad++; end
      else a.req_valid = 1'b0;
      if (b.busy === 1'b1) begin nb++; if (b.req_ready !== 1'b0 || b.rsp_valid !== 1'b0) bad++; end
      else b.req_valid = 1'b0;
      tick();
    end
    idle_all();
    total++;
    if (na != int'(DA)) $display("FAIL clear_len_a: got %0d cycles, required %0d", na, DA); else passed++;
    total++;
    if (nb != int'(DB)) $display("FAIL clear_len_b: got %0d cycles, required %0d", nb, DB); else passed++;
    total++;
    if (bad != 0) $display("FAIL ready_during_clear: got %0d bad cycles, required 0", bad); else passed++;
    total++;
    if (a.req_ready !== 1'b1 || b.req_ready !== 1'b1 || a.busy !== 1'b0)
      $display("FAIL ready_after_clear: a=%b b=%b busy=%b, required 1 1 0", a.req_ready, b.req_ready, a.busy);
    else passed++;
  endtask

  task automatic test_clear_contents();
    exp_t x;
    logic [DW-1:0] ed;
    for (int i = 0; i <= int'(DA); i++) begin
      if (i < int'(DA)) drive_a(1'b1, 1'b0, AWA'(i), 8'h00, 1'b0);
      else              drive_a(1'b0, 1'b0, '0, 8'h00, 1'b0);
      tick();
      x = qa.pop_front();
      ed = x.v ? x.d : last_a;
      total++;
      if (a.rsp_valid !== x.v || a.rsp_rdata !== ed)
        $display("FAIL clear_read[%0d]: v=%b d=%h, required v=%b d=%h", i, a.rsp_valid, a.rsp_rdata, x.v, ed);
      else passed++;
      last_a = ed;
    end
  endtask

  task automatic test_write_read();
    exp_t x;
    logic [DW-1:0] ed;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive_a(1'b1, 1'b1, 5'd7, 8'hA5, 1'b0);
        1: drive_a(1'b1, 1'b0, 5'd7, 8'h00, 1'b0);
        default: drive_a(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
      endcase
      tick();
      x = qa.pop_front();
      ed = x.v ? x.d : last_a;
      total++;
      if (a.rsp_valid !== x.v || a.rsp_rdata !== ed)
        $display("FAIL write_read[%0d]: v=%b d=%h, required v=%b d=%h", i, a.rsp_valid, a.rsp_rdata, x.v, ed);
      else passed++;
      last_a = ed;
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    logic [DW-1:0] ed;
    logic [AWA-1:0] ad;
    int not_ready;
    not_ready = 0;
    ad = '0;
    for (int i = 0; i < 36; i++) begin
      if (i < 32) begin
        if ((i % 2) == 0) begin
          ad = AWA'($urandom_range(0, DA - 1));
          drive_a(1'b1, 1'b1, ad, DW'($urandom_range(0, 255)), 1'b0);
        end else begin
          drive_a(1'b1, 1'b0, ad, 8'h00, 1'b0);
        end
        if (a.req_ready !== 1'b1) not_ready++;
      end else begin
        drive_a(1'b0, 1'b0, '0, 8'h00, 1'b0);
      end
      tick();
      x = qa.pop_front();
      ed = x.v ? x.d : last_a;
      total++;
      if (a.rsp_valid !== x.v || a.rsp_rdata !== ed)
        $display("FAIL b2b[%0d]: v=%b d=%h, required v=%b d=%h", i, a.rsp_valid, a.rsp_rdata, x.v, ed);
      else passed++;
      last_a = ed;
    end
    total++;
    if (not_ready != 0) $display("FAIL b2b_ready: got %0d stalled cycles, required 0", not_ready);
    else passed++;
  endtask

  task automatic test_reset_mid_clear();
    exp_t x;
    logic [DW-1:0] ed;
    int n, bad;
    idle_all();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    repeat (10) tick();
    total++;
    if (a.busy !== 1'b1) $display("FAIL busy_mid_clear: got %b, required 1", a.busy); else passed++;
    rst_a = 1'b1;
    tick();
    total++;
    if (a.busy !== 1'b1 || a.req_ready !== 1'b0 || a.rsp_rdata !== 8'h00 || a.rsp_valid !== 1'b0)
      $display("FAIL reset_mid_clear: busy=%b rdy=%b d=%h v=%b, required 1 0 00 0",
               a.busy, a.req_ready, a.rsp_rdata, a.rsp_valid);
    else passed++;
    rst_a = 1'b0;
    for (int i = 0; i < int'(DA); i++) begin ma[i] = 8'h00; ea[i] = 1'b0; end
    last_a = 8'h00;
    qa.delete();
    n = 0; bad = 0;
    for (int c = 0; c < 100 && a.busy === 1'b1; c++) begin
      n++;
      a.req_valid = 1'b1; a.req_we = c[0]; a.req_addr = AWA'(c); a.req_wdata = 8'hFF;
      if (a.req_ready !== 1'b0 || a.rsp_valid !== 1'b0) bad++;
      tick();
    end
    idle_all();
    total++;
    if (n != int'(DA) || bad != 0)
      $display("FAIL restart_clear: got %0d cycles %0d bad, required %0d cycles 0 bad", n, bad, DA);
    else passed++;
    for (int i = 0; i <= int'(DA); i++) begin
      if (i < int'(DA)) drive_a(1'b1, 1'b0, AWA'(i), 8'h00, 1'b0);
      else              drive_a(1'b0, 1'b0, '0, 8'h00, 1'b0);
      tick();
      x = qa.pop_front();
      ed = x.v ? x.d : last_a;
      total++;
      if (a.rsp_valid !== x.v || a.rsp_rdata !== ed)
        $display("FAIL reclear_read[%0d]: v=%b d=%h, required v=%b d=%h", i, a.rsp_valid, a.rsp_rdata, x.v, ed);
      else passed++;
      last_a = ed;
    end
  endtask

  task automatic test_out_of_range();
    exp_t x;
    logic [DW-1:0] ed;
    for (int i = 0; i < 25; i++) begin
      case (i)
        0: drive_b(1'b1, 1'b1, 5'd5, 8'h11);
        1: drive_b(1'b1, 1'b1, 5'd25, 8'h3C);
        2: drive_b(1'b1, 1'b0, 5'd25, 8'h00);
        23: drive_b(1'b1, 1'b0, 5'd31, 8'h00);
        24: drive_b(1'b0, 1'b0, 5'd0, 8'h00);
        default: drive_b(1'b1, 1'b0, AWB'(i - 3), 8'h00);
      endcase
      tick();
      x = qb.pop_front();
      ed = x.v ? x.d : last_b;
      total++;
      if (b.rsp_valid !== x.v || b.rsp_rdata !== ed)
        $display("FAIL oob[%0d]: v=%b d=%h, required v=%b d=%h", i, b.rsp_valid, b.rsp_rdata, x.v, ed);
      else passed++;
      last_b = ed;
    end
  endtask

`ifdef PARAM_DATA_MEMORY_PARITY_EN
  task automatic test_parity();
    exp_t x;
    logic [DW-1:0] ed;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive_a(1'b1, 1'b1, 5'd3, 8'h01, 1'b1);
        1: drive_a(1'b1, 1'b1, 5'd4, 8'h01, 1'b0);
        2: drive_a(1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
        3: drive_a(1'b1, 1'b0, 5'd4, 8'h00, 1'b0);
        default: drive_a(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
      endcase
      tick();
      x = qa.pop_front();
      ed = x.v ? x.d : last_a;
      total++;
      if (a.rsp_valid !== x.v || a.rsp_rdata !== ed || a.rsp_parity_err !== x.e)
        $display("FAIL parity[%0d]: v=%b d=%h err=%b, required v=%b d=%h err=%b",
                 i, a.rsp_valid, a.rsp_rdata, a.rsp_parity_err, x.v, ed, x.e);
      else passed++;
      last_a = ed;
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total  = 0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    idle_all();
    test_reset();
    test_clear_contents();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
`ifdef PARAM_DATA_MEMORY_PARITY_EN
    test_parity();
`endif
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
